// File: rtl/zeroriscy_fft_seq_unit.sv
// Custom0 EX-stage responder for complex Q15 FFT primitives.
// CMUL and the butterflies share one 16x16 multiplier over four cycles. CADDS and BITREV answer in the same cycle.
module zeroriscy_fft_seq_unit #(
  parameter bit SATURATE = 1'b1,
  parameter bit ROUND    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        custom0_sel_i,
  input  logic [4:0]  custom0_operator_i,
  input  logic [31:0] custom0_operand_a_i,
  input  logic [31:0] custom0_operand_b_i,
  input  logic [31:0] custom0_operand_c_i,
  output logic [31:0] result_o,
  output logic        ready_o
);

  localparam int unsigned XW  = 32;
  localparam int unsigned HW  = 16;
  localparam int unsigned OPW = 5;
  localparam int unsigned AW  = 34;
  localparam int unsigned TW  = 35;
  localparam int unsigned RW  = 19;

  localparam logic [OPW-1:0] OP_CMUL   = 5'd0;
  localparam logic [OPW-1:0] OP_BTOP   = 5'd1;
  localparam logic [OPW-1:0] OP_BBOT   = 5'd2;
  localparam logic [OPW-1:0] OP_CADDS  = 5'd3;
  localparam logic [OPW-1:0] OP_BITREV = 5'd4;

  localparam logic signed [RW-1:0] QMAX = 19'sd32767;
  localparam logic signed [RW-1:0] QMIN = -19'sd32768;
  localparam logic signed [AW-1:0] HALF_C = ROUND ? 34'sd16384 : 34'sd0;
  localparam logic signed [TW-1:0] HALF_B = ROUND ? 35'sd32768 : 35'sd0;
  localparam logic signed [HW:0]   HALF_A = ROUND ? 17'sd1 : 17'sd0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

  state_t state, state_next;
  logic [1:0]             cnt;
  logic [OPW-1:0]         op_q;
  logic [XW-1:0]          a_q, b_q, c_q, res_q;
  logic signed [AW-1:0]   acc_re, acc_im, acc_re_nxt, acc_im_nxt, prod_x;
  logic signed [HW-1:0]   mul_a, mul_b;
  logic signed [XW-1:0]   prod;
  logic [XW-1:0]          mul_res, single_res;
  logic                   is_multi;

  // Clamp or wrap a shifted intermediate to a Q15 lane.
  function automatic logic [HW-1:0] clip(input logic signed [RW-1:0] v);
    logic [HW-1:0] r;
    r = v[HW-1:0];
    if (SATURATE) begin
      if (v > QMAX)      r = 16'h7FFF;
      else if (v < QMIN) r = 16'h8000;
    end
    return r;
  endfunction

  function automatic logic [HW-1:0] cmul_round(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] t;
    t = acc + HALF_C;
    return clip(t[AW-1:HW-1]);
  endfunction

  function automatic logic [HW-1:0] bfly_round(input logic [HW-1:0] c,
                                               input logic signed [AW-1:0] acc,
                                               input logic sub);
    logic signed [TW-1:0] cx, ax, t;
    cx = {{4{c[HW-1]}}, c, 15'd0};
    ax = {acc[AW-1], acc};
    t  = sub ? (cx - ax) : (cx + ax);
    t  = t + HALF_B;
    return clip(t[TW-1:HW]);
  endfunction

  function automatic logic [HW-1:0] cadd_half(input logic [HW-1:0] x, input logic [HW-1:0] y);
    logic signed [HW:0] s;
    s = $signed({x[HW-1], x}) + $signed({y[HW-1], y}) + HALF_A;
    return s[HW:1];
  endfunction

  // Full 32-bit reversal, then shift the reversed field down to bit 0; n=0 shifts everything out.
  function automatic logic [XW-1:0] bitrev(input logic [XW-1:0] v, input logic [4:0] n);
    logic [XW-1:0] r;
    logic [5:0]    sh;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    sh = 6'd32 - {1'b0, n};
    return r >> sh;
  endfunction

  assign is_multi = (custom0_operator_i <= OP_BBOT);

  // Shared multiplier: cnt 0..3 selects ar*br, ai*bi, ar*bi, ai*br.
  always_comb begin
    mul_a      = cnt[0] ? a_q[HW-1:0] : a_q[XW-1:HW];
    mul_b      = (cnt[0] ^ cnt[1]) ? b_q[HW-1:0] : b_q[XW-1:HW];
    prod       = mul_a * mul_b;
    prod_x     = {{2{prod[XW-1]}}, prod};
    acc_re_nxt = acc_re;
    acc_im_nxt = acc_im;
    case (cnt)
      2'd0:    acc_re_nxt = acc_re + prod_x;
      2'd1:    acc_re_nxt = acc_re - prod_x;
      default: acc_im_nxt = acc_im + prod_x;
    endcase
  end

  always_comb begin
    mul_res = '0;
    case (op_q)
      OP_CMUL: mul_res = {cmul_round(acc_re_nxt), cmul_round(acc_im_nxt)};
      OP_BTOP: mul_res = {bfly_round(c_q[XW-1:HW], acc_re_nxt, 1'b0),
                          bfly_round(c_q[HW-1:0],  acc_im_nxt, 1'b0)};
      OP_BBOT: mul_res = {bfly_round(c_q[XW-1:HW], acc_re_nxt, 1'b1),
                          bfly_round(c_q[HW-1:0],  acc_im_nxt, 1'b1)};
      default: mul_res = '0;
    endcase
  end

  always_comb begin
    single_res = '0;
    case (custom0_operator_i)
      OP_CADDS:  single_res = {cadd_half(custom0_operand_a_i[XW-1:HW], custom0_operand_b_i[XW-1:HW]),
                               cadd_half(custom0_operand_a_i[HW-1:0],  custom0_operand_b_i[HW-1:0])};
      OP_BITREV: single_res = bitrev(custom0_operand_a_i, custom0_operand_b_i[4:0]);
      default:   single_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (custom0_sel_i && is_multi) state_next = S_MUL;
      S_MUL:   if (!custom0_sel_i)          state_next = S_IDLE;
               else if (cnt == 2'd3)        state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture and accumulation; result latched on the MUL->DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      acc_re <= '0;
      acc_im <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (custom0_sel_i && is_multi) begin
          op_q   <= custom0_operator_i;
          a_q    <= custom0_operand_a_i;
          b_q    <= custom0_operand_b_i;
          c_q    <= custom0_operand_c_i;
          acc_re <= '0;
          acc_im <= '0;
          cnt    <= '0;
        end
        S_MUL: if (custom0_sel_i) begin
          acc_re <= acc_re_nxt;
          acc_im <= acc_im_nxt;
          cnt    <= cnt + 2'd1;
          if (cnt == 2'd3) res_q <= mul_res;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ready_o  = 1'b0;
    result_o = '0;
    case (state)
      S_IDLE: if (custom0_sel_i && !is_multi) begin
        ready_o  = 1'b1;
        result_o = single_res;
      end
      S_DONE: begin
        ready_o  = 1'b1;
        result_o = res_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_zeroriscy_fft_seq_unit.sv
// Scoreboard bench: saturating and wrapping instances share stimulus.
// A behavioural model predicts each result and the cycle it should appear in.
module tb_zeroriscy_fft_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [4:0]  op;
  logic [31:0] a, b, c;
  logic [31:0] res_s, res_w;
  logic        rdy_s, rdy_w;

  always #5 clk = ~clk;

  zeroriscy_fft_seq_unit #(.SATURATE(1'b1), .ROUND(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .custom0_sel_i(sel), .custom0_operator_i(op),
    .custom0_operand_a_i(a), .custom0_operand_b_i(b), .custom0_operand_c_i(c),
    .result_o(res_s), .ready_o(rdy_s));

  zeroriscy_fft_seq_unit #(.SATURATE(1'b0), .ROUND(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .custom0_sel_i(sel), .custom0_operator_i(op),
    .custom0_operand_a_i(a), .custom0_operand_b_i(b), .custom0_operand_c_i(c),
    .result_o(res_w), .ready_o(rdy_w));

  typedef struct { logic [31:0] res; int cyc; logic [4:0] op; } exp_t;
  exp_t q_s[$], q_w[$];
  exp_t es, ew;
  int total = 0, bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] fit(input longint v, input bit sat);
    if (sat && v > 32767)  return 16'h7FFF;
    if (sat && v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // Reference model with plain integer arithmetic (floor division via >>> on longint).
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] z, input bit sat);
    longint ar, ai, br, bi, cr, ci, pr, pi;
    logic [31:0] r;
    int n;
    ar = longint'($signed(x[31:16])); ai = longint'($signed(x[15:0]));
    br = longint'($signed(y[31:16])); bi = longint'($signed(y[15:0]));
    cr = longint'($signed(z[31:16])); ci = longint'($signed(z[15:0]));
    pr = ar * br - ai * bi;
    pi = ar * bi + ai * br;
    r  = '0;
    case (o)
      5'd0: r = {fit((pr + 16384) >>> 15, sat), fit((pi + 16384) >>> 15, sat)};
      5'd1: r = {fit((cr * 32768 + pr + 32768) >>> 16, sat), fit((ci * 32768 + pi + 32768) >>> 16, sat)};
      5'd2: r = {fit((cr * 32768 - pr + 32768) >>> 16, sat), fit((ci * 32768 - pi + 32768) >>> 16, sat)};
      5'd3: r = {fit((ar + br + 1) >>> 1, sat), fit((ai + bi + 1) >>> 1, sat)};
      5'd4: begin
        n = int'(y[4:0]);
        for (int i = 0; i < n; i++) r[n-1-i] = x[i];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  always @(negedge clk) if (rst_n === 1'b1 && rdy_s === 1'b1) begin
    total++;
    if (q_s.size() == 0) begin
      bad++;
      $display("FAIL sat_unexpected_ready: cycle %0d result %h, required no ready", cyc, res_s);
    end else begin
      es = q_s.pop_front();
      if (res_s !== es.res || cyc != es.cyc) begin
        bad++;
        $display("FAIL sat_op%0d: result %h at cycle %0d, required %h at cycle %0d",
                 es.op, res_s, cyc, es.res, es.cyc);
      end
    end
  end

  always @(negedge clk) if (rst_n === 1'b1 && rdy_w === 1'b1) begin
    total++;
    if (q_w.size() == 0) begin
      bad++;
      $display("FAIL wrap_unexpected_ready: cycle %0d result %h, required no ready", cyc, res_w);
    end else begin
      ew = q_w.pop_front();
      if (res_w !== ew.res || cyc != ew.cyc) begin
        bad++;
        $display("FAIL wrap_op%0d: result %h at cycle %0d, required %h at cycle %0d",
                 ew.op, res_w, cyc, ew.res, ew.cyc);
      end
    end
  end

  // Issue one instruction; multi-cycle ops scramble the live operands while in flight.
  task automatic issue(input logic [4:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ic, input bit keep);
    exp_t e;
    @(posedge clk); #1;
    sel = 1'b1; op = o; a = ia; b = ib; c = ic;
    e.op = o;
    e.cyc = (o <= 5'd2) ? cyc + 5 : cyc;
    e.res = model(o, ia, ib, ic, 1'b1); q_s.push_back(e);
    e.res = model(o, ia, ib, ic, 1'b0); q_w.push_back(e);
    if (o <= 5'd2) begin
      repeat (4) begin
        @(posedge clk); #1;
        a = $urandom; b = $urandom; c = $urandom;
      end
      @(posedge clk); #1;
    end
    if (!keep) begin
      if (o > 5'd2) begin @(posedge clk); #1; end
      sel = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_8000;
      1:       return 32'h7FFF_7FFF;
      2:       return {16'h8000, 16'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0]  ro;
    bit          rk;
    rst_n = 1'b0; sel = 1'b0; op = '0; a = '0; b = '0; c = '0;
    #12;
    chk("reset_ready", {31'd0, rdy_s}, 32'd0);
    chk("reset_result", res_s, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, rdy_w}, 32'd0);
    chk("idle_result", res_w, 32'd0);

    issue(5'd0, 32'h4000_0000, 32'h4000_0000, 32'h0, 1'b0);
    issue(5'd0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b0);
    issue(5'd1, 32'h4000_0000, 32'h7FFF_0000, 32'h2000_0000, 1'b0);
    issue(5'd2, 32'h4000_0000, 32'h7FFF_0000, 32'h2000_0000, 1'b0);
    issue(5'd4, 32'h0000_0001, 32'd4, 32'h0, 1'b0);
    issue(5'd3, 32'h0003_FFFF, 32'h0002_FFFF, 32'h0, 1'b0);
    issue(5'd4, 32'hDEAD_BEEF, 32'd0, 32'h0, 1'b0);
    issue(5'd4, 32'hDEAD_BEEF, 32'd31, 32'h0, 1'b0);
    issue(5'd9, 32'h1234_5678, 32'h1111_2222, 32'h3333_4444, 1'b0);

    // Back-to-back chain with sel held across instructions.
    issue(5'd0, 32'h7FFF_8000, 32'h8000_7FFF, 32'h0, 1'b1);
    issue(5'd2, 32'h1234_EDCB, 32'h5A5A_A5A5, 32'h8000_7FFF, 1'b1);
    issue(5'd3, 32'h8000_7FFF, 32'h8000_7FFF, 32'h0, 1'b1);
    issue(5'd1, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_7FFF, 1'b1);
    issue(5'd4, 32'hF0F0_1234, 32'd13, 32'h0, 1'b0);

    // Abort: drop sel in MUL, then start a fresh CMUL two cycles later.
    @(posedge clk); #1; sel = 1'b1; op = 5'd0; a = 32'h4000_4000; b = 32'h4000_4000;
    @(posedge clk); #1;
    @(posedge clk); #1; sel = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, rdy_s}, 32'd0);
    @(posedge clk); #1;
    issue(5'd0, 32'h2000_E000, 32'h6000_1000, 32'h0, 1'b0);

    // Reset mid-operation.
    @(posedge clk); #1; sel = 1'b1; op = 5'd0; a = 32'h4000_0000; b = 32'h4000_0000;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0; #2;
    chk("midreset_ready", {31'd0, rdy_s}, 32'd0);
    chk("midreset_result", res_s, 32'd0);
    chk("midreset_result_wrap", res_w, 32'd0);
    @(posedge clk); #1; sel = 1'b0; rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_idle", {rdy_s, rdy_w, res_s[29:0] | res_w[29:0]}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      ro = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(5, 31)) : 5'($urandom_range(0, 4));
      rk = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
      issue(ro, pick(), pick(), pick(), rk);
    end

    for (int i = 0; i < 50 && (q_s.size() != 0 || q_w.size() != 0); i++) @(posedge clk);
    if (q_s.size() != 0 || q_w.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, required 0", q_s.size(), q_w.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zeroriscy_fft_seq_unit.md
Name: zeroriscy_fft_seq_unit

Overview:
Multi-cycle responder on the EX-stage custom0 interface. It executes complex Q15 FFT primitives (complex multiply, scaled butterflies, scaled add, bit-reverse) using one shared 16x16 signed multiplier. While `custom0_sel_i` is asserted it owns the instruction and signals completion through `ready_o`. The EX block feeds `ready_o` into its `ex_ready_o` mux and takes `result_o` for regfile write-back.

Parameters:
SATURATE, 1, 1 = clamp Q15 results to [-32768, 32767]; 0 = wrap (truncate to 16 bits).
ROUND, 1, 1 = add half-LSB before every arithmetic right shift; 0 = plain truncation.

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
custom0_sel_i  input  1  custom0 instruction present in EX; held high until ready_o
custom0_operator_i  input  5  operation select
custom0_operand_a_i  input  32  complex sample {re[31:16], im[15:0]}, Q15
custom0_operand_b_i  input  32  complex twiddle / second operand, Q15; bits [4:0] = width for BITREV
custom0_operand_c_i  input  32  complex butterfly input, Q15
result_o  output  32  {re, im} result; valid only when ready_o=1
ready_o  output  1  result valid / instruction complete this cycle

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: FSM=IDLE, cnt=0, accumulators=0, captured operands=0, result_o=0, ready_o=0.
- Operators:
  - 0 CMUL: a*b.
  - 1 BFLY_TOP: (c + a*b)/2.
  - 2 BFLY_BOT: (c - a*b)/2.
  - 3 CADDS: (a+b)/2 per component.
  - 4 BITREV: reverse the low N bits of a, N = b[4:0]. N=0 -> result 0. N>=1 -> result bits [31:N] zero.
  - 5..31: result 0.
- Single-cycle ops (3, 4, invalid): computed combinationally from the live operands. ready_o=1 in the same cycle custom0_sel_i is high while in IDLE. No state change.
- Multi-cycle ops (0..2), FSM IDLE -> MUL -> DONE -> IDLE:
  - IDLE, sel=1, op in 0..2: capture a, b, c, op; clear accumulators; cnt=0; go to MUL. ready_o=0.
  - MUL: one product per cycle. cnt0 ar*br, cnt1 ai*bi, cnt2 ar*bi, cnt3 ai*br.
  - MUL accumulation: acc_re = p0 - p1, acc_im = p2 + p3, each 34-bit signed (products are Q30, 32-bit).
  - MUL exit: after cnt==3 -> DONE, with result_o registered on that transition.
  - DONE: ready_o=1, result_o held; unconditional return to IDLE next cycle.
- Latency: sel first seen at cycle T -> ready_o=1 at cycle T+5, for exactly one cycle.
- Arithmetic, CMUL: r = (acc + 2^14) >>> 15 (rounding term omitted if ROUND=0), then sat/wrap to 16 bits.
- Arithmetic, BFLY: t = (c_part <<< 15) ± acc (35-bit); r = (t + 2^15) >>> 16, then sat/wrap.
- Arithmetic, CADDS: r = (x + y + 1) >>> 1, 17-bit intermediate; result always fits in 16 bits.
- Operand stability: captured operands are used for multi-cycle ops. Changes on inputs during MUL are ignored.
- Abort: custom0_sel_i low in MUL -> return to IDLE next cycle. No ready_o pulse, result_o stays 0.
- Back-to-back: sel held high after the DONE cycle starts a new instruction from IDLE on the following cycle, with no bubble beyond the IDLE capture cycle.
- Idle outputs: when sel=0 in IDLE, ready_o=0 and result_o=0.
- Reset mid-operation: asserting rst_n low forces reset values immediately; no stale result after release.

Test Plan:
- CMUL a=0x4000_0000, b=0x4000_0000 (0.5*0.5), sel high from T -> ready_o=1 only at T+5, result_o=0x2000_0000.
- CMUL a=0x8000_0000, b=0x8000_0000 (-1*-1) -> with SATURATE=1, result_o=0x7FFF_0000; with SATURATE=0, result_o=0x8000_0000.
- BFLY_TOP c=0x2000_0000, a=0x4000_0000, b=0x7FFF_0000 -> result_o=0x3000_0000 at T+5. BFLY_BOT with the same operands -> result_o=0xF000_0000.
- BITREV a=0x0000_0001, b=4 -> result_o=0x0000_0008 with ready_o=1 in the same cycle. CADDS a=0x0003_FFFF, b=0x0002_FFFF -> result_o=0x0003_FFFF.
- Abort: CMUL started at T, sel deasserted at T+2 -> no ready_o pulse. A new CMUL started at T+4 completes at T+9 with the correct value.
- Reset: assert rst_n at T+3 of a CMUL -> result_o=0 and ready_o=0 immediately. After release, an idle sel=0 cycle keeps both outputs at 0.
